// File: rtl/mem_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: aluop codes, reset level,
// bus width, access-size encoding and the byte-lane select helper.
package mem_lsu_pkg;

  localparam int               RegBus    = 32;
  localparam logic             RstEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_BYTE = 2'd1,
    ACC_HALF = 2'd2,
    ACC_WORD = 2'd3
  } acc_size_e;

  // Big-endian lane select: offset 0 addresses the most significant lane.
  function automatic logic [3:0] lane_sel(acc_size_e sz, logic [1:0] off);
    logic [3:0] sel;
    case (sz)
      ACC_BYTE: sel = 4'b1000 >> off;
      ACC_HALF: sel = off[1] ? 4'b0011 : 4'b1100;
      ACC_WORD: sel = 4'b1111;
      default:  sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_llbit_reg.sv
// LLbit register for LL/SC. Cleared by reset or pipeline flush; otherwise
// loaded with din when we is asserted.
module mem_llbit_reg (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic we,
  input  logic din,
  output logic dout
);
  import mem_lsu_pkg::*;

  logic llbit_q;

  // Reset has priority over flush; a flush always kills the reservation.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      llbit_q <= 1'b0;
    end else if (flush_i) begin
      llbit_q <= 1'b0;
    end else if (we) begin
      llbit_q <= din;
    end
  end

  assign dout = llbit_q;

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the byte-lane data RAM, aligns and
// extends load data, detects misaligned accesses and owns the MEM/WB register.
// Optional feature: define LLSC_EN to build the LLbit and conditional SC;
// without it LL acts as LW and SC always stores and returns 1.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o
);

  acc_size_e   acc_size;
  logic        is_load, is_store, is_sc, ld_signed;
  logic        misalign, active, sc_ok, access;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data, result;
  logic [4:0]  wb_wd_q, wb_wd_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;

  // Opcode decode into access size, direction and extension.
  always_comb begin
    acc_size  = ACC_NONE;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_sc     = 1'b0;
    ld_signed = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin acc_size = ACC_BYTE; is_load = 1'b1; ld_signed = 1'b1; end
      EXE_LBU_OP: begin acc_size = ACC_BYTE; is_load = 1'b1; end
      EXE_LH_OP:  begin acc_size = ACC_HALF; is_load = 1'b1; ld_signed = 1'b1; end
      EXE_LHU_OP: begin acc_size = ACC_HALF; is_load = 1'b1; end
      EXE_LW_OP,
      EXE_LL_OP:  begin acc_size = ACC_WORD; is_load = 1'b1; end
      EXE_SB_OP:  begin acc_size = ACC_BYTE; is_store = 1'b1; end
      EXE_SH_OP:  begin acc_size = ACC_HALF; is_store = 1'b1; end
      EXE_SW_OP:  begin acc_size = ACC_WORD; is_store = 1'b1; end
      EXE_SC_OP:  begin acc_size = ACC_WORD; is_store = 1'b1; is_sc = 1'b1; end
      default:    ;
    endcase
  end

  assign misalign = ((acc_size == ACC_HALF) && mem_addr_i[0]) ||
                    ((acc_size == ACC_WORD) && (mem_addr_i[1:0] != 2'b00));
  assign active   = !stall_i && !flush_i;

`ifdef LLSC_EN
  logic llbit, ll_we, ll_din;

  // LL sets the reservation; a successful SC consumes it.
  assign ll_we  = active && !misalign &&
                  ((aluop_i == EXE_LL_OP) || (is_sc && llbit));
  assign ll_din = (aluop_i == EXE_LL_OP);
  assign sc_ok  = llbit;

  mem_llbit_reg u_llbit (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .we      (ll_we),
    .din     (ll_din),
    .dout    (llbit)
  );
`else
  assign sc_ok = 1'b1;
`endif

  // A failed SC behaves like an access that never reaches the RAM.
  assign access     = (is_load || is_store) && active && !misalign && !(is_sc && !sc_ok);
  assign mem_ce_o   = access;
  assign mem_we_o   = access && is_store;
  assign mem_addr_o = mem_addr_i;
  assign mem_sel_o  = access ? lane_sel(acc_size, mem_addr_i[1:0]) : 4'b0000;
  assign adel_o     = active && is_load && misalign;
  assign ades_o     = active && is_store && misalign;

  // Store data replicated across lanes so the RAM only needs the select.
  always_comb begin
    case (acc_size)
      ACC_BYTE: mem_data_o = {4{reg2_i[7:0]}};
      ACC_HALF: mem_data_o = {2{reg2_i[15:0]}};
      default:  mem_data_o = reg2_i;
    endcase
  end

  // Pick the addressed byte/half (big-endian) and extend to a word.
  always_comb begin
    case (mem_addr_i[1:0])
      2'b00:   byte_v = mem_data_i[31:24];
      2'b01:   byte_v = mem_data_i[23:16];
      2'b10:   byte_v = mem_data_i[15:8];
      default: byte_v = mem_data_i[7:0];
    endcase
    half_v = mem_addr_i[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (acc_size)
      ACC_BYTE: load_data = ld_signed ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      ACC_HALF: load_data = ld_signed ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      default:  load_data = mem_data_i;
    endcase
    if (is_load)    result = load_data;
    else if (is_sc) result = {31'd0, sc_ok};
    else            result = wdata_i;
  end

  // Next MEM/WB entry: bubble on stall/flush, write suppressed on misalign.
  always_comb begin
    wb_wd_d    = wd_i;
    wb_wreg_d  = wreg_i && !misalign;
    wb_wdata_d = result;
    if (!active) begin
      wb_wd_d    = 5'd0;
      wb_wreg_d  = 1'b0;
      wb_wdata_d = ZeroWord;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wb_wd_q    <= 5'd0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= ZeroWord;
    end else begin
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign wb_wd_o    = wb_wd_q;
  assign wb_wreg_o  = wb_wreg_q;
  assign wb_wdata_o = wb_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: each cycle the stimulus computes the expected
// RAM-side outputs and the expected WB entry from a behavioural model and
// queues them; a monitor on the falling edge pops and compares.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall_i = 1'b0, flush_i = 1'b0, wreg_i = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [4:0]  wd_i = '0;
  logic [31:0] wdata_i = '0, mem_addr_i = '0, reg2_i = '0, mem_data_i = '0;
  logic        mem_ce_o, mem_we_o, adel_o, ades_o, wb_wreg_o;
  logic [31:0] mem_addr_o, mem_data_o, wb_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [4:0]  wb_wd_o;

  mem_lsu dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .aluop_i(aluop_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .mem_data_i(mem_data_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
    .adel_o(adel_o), .ades_o(ades_o),
    .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          tag;
    logic        ce, we, adel, ades;
    logic [3:0]  sel;
    logic [31:0] addr, data;
  } comb_t;

  typedef struct {
    int          tag;
    logic        full;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_t;

  comb_t comb_q[$];
  wb_t   wb_q[$];
  int    checks = 0, failures = 0, ntx = 0;
  logic  llbit_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare RAM-side outputs of the current cycle, and the WB entry
  // registered at the previous rising edge.
  always @(negedge clk) begin
    if (comb_q.size() > 0 && comb_q[0].tag == cyc) begin
      comb_t c;
      c = comb_q.pop_front();
      chk("ce", {31'd0, mem_ce_o}, {31'd0, c.ce});
      chk("we", {31'd0, mem_we_o}, {31'd0, c.we});
      chk("adel", {31'd0, adel_o}, {31'd0, c.adel});
      chk("ades", {31'd0, ades_o}, {31'd0, c.ades});
      chk("addr", mem_addr_o, c.addr);
      if (c.ce) chk("sel", {28'd0, mem_sel_o}, {28'd0, c.sel});
      if (c.we) chk("wdat", mem_data_o, c.data);
    end
    if (wb_q.size() > 0 && wb_q[0].tag < cyc) begin
      wb_t w;
      w = wb_q.pop_front();
      chk("wb_wreg", {31'd0, wb_wreg_o}, {31'd0, w.wreg});
      if (w.full) begin
        chk("wb_wd", {27'd0, wb_wd_o}, {27'd0, w.wd});
        chk("wb_wdata", wb_wdata_o, w.wdata);
      end
    end
  end

  // One MEM-stage cycle: drive inputs, derive expectations from the rules.
  task automatic txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                     input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] wd,
                     input logic wreg, input logic st, input logic fl, input logic rs);
    comb_t c;
    wb_t   w;
    bit    ld, sto, sc, sgn, mis, go, llv, ok;
    int    nb, off;
    logic [63:0] v, mask;
    @(posedge clk);
    #1;
    aluop_i = op; mem_addr_i = addr; reg2_i = rt; wdata_i = alu; mem_data_i = rdata;
    wd_i = wd; wreg_i = wreg; stall_i = st; flush_i = fl; rst = rs;

    ld  = op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP};
    sto = op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP};
    sc  = (op == EXE_SC_OP);
    sgn = op inside {EXE_LB_OP, EXE_LH_OP};
    nb  = (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) ? 1 :
          (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? 2 : 4;
    off = int'(addr % 4);
    mis = (ld || sto) && (off % nb != 0);
    go  = !st && !fl;
`ifdef LLSC_EN
    llv = llbit_m;
`else
    llv = 1'b1;
`endif
    ok = go && (ld || sto) && !mis && !(sc && !llv);

    c.tag = cyc; c.addr = addr;
    c.ce = ok; c.we = ok && sto;
    c.adel = go && ld && mis; c.ades = go && sto && mis;
    c.sel = '0;
    for (int i = 0; i < nb; i++) c.sel[3 - ((off + i) % 4)] = 1'b1;
    c.data = '0;
    for (int ln = 0; ln < 4; ln++) c.data[8*ln +: 8] = rt[8*(ln % nb) +: 8];

    mask = (64'd1 << (8*nb)) - 64'd1;
    v = ({32'd0, rdata} >> (8*(4 - off - nb))) & mask;
    if (sgn && v[8*nb-1]) v = v | ~mask;

    w.tag = cyc; w.full = 1'b1; w.wd = '0; w.wreg = 1'b0; w.wdata = '0;
    if (!rs && go) begin
      w.full  = !mis;
      w.wd    = wd;
      w.wreg  = wreg && !mis;
      w.wdata = ld ? v[31:0] : sc ? {31'd0, llv} : alu;
    end
    comb_q.push_back(c);
    wb_q.push_back(w);

`ifdef LLSC_EN
    if (rs || fl) llbit_m = 1'b0;
    else if (go && !mis && op == EXE_LL_OP) llbit_m = 1'b1;
    else if (go && !mis && sc && llbit_m) llbit_m = 1'b0;
`endif
    ntx++;
    $display("txn %0d op=%h addr=%h rt=%h rdata=%h st=%b fl=%b rst=%b exp_ce=%b exp_wb=%h",
             ntx, op, addr, rt, rdata, st, fl, rs, c.ce, w.wdata);
  endtask

  localparam logic [7:0] NOP_OP = 8'b0010_0001;

  initial begin
    logic [7:0] ops[11];
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP,
            EXE_SH_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP, NOP_OP};

    // Reset: WB register must read all zero.
    txn(NOP_OP, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    txn(NOP_OP, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    // Directed cases.
    txn(EXE_LB_OP, 32'h0000_0101, 32'h0, 32'h0, 32'h1182_3344, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(EXE_SH_OP, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    txn(EXE_LW_OP, 32'h0000_0106, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(EXE_LL_OP, 32'h0000_0040, 32'h0, 32'h0, 32'hA5A5_0001, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(EXE_SC_OP, 32'h0000_0040, 32'h7, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(EXE_SC_OP, 32'h0000_0040, 32'h7, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(EXE_LL_OP, 32'h0000_0080, 32'h0, 32'h0, 32'h0000_0042, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(NOP_OP, 32'h0, 32'h0, 32'h55, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    txn(EXE_SC_OP, 32'h0000_0080, 32'h9, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(EXE_SW_OP, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    txn(EXE_LL_OP, 32'h0000_0020, 32'h0, 32'h0, 32'h1111_2222, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    txn(EXE_SC_OP, 32'h0000_0020, 32'h3, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    txn(EXE_LL_OP, 32'h0000_0030, 32'h0, 32'h0, 32'h3333_4444, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    txn(EXE_SC_OP, 32'h0000_0030, 32'h3, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; plain stores carry no register write.
    for (int n = 0; n < 400; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      logic        wr;
      op = ops[$urandom_range(10, 0)];
      a  = $urandom;
      if ($urandom_range(3, 0) != 0) a[1:0] = (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ?
                                               {a[1], 1'b0} : (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) ? a[1:0] : 2'b00;
      wr = (op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP}) ? 1'b0 : 1'($urandom_range(1, 0));
      txn(op, a, $urandom, $urandom, $urandom, 5'($urandom_range(31, 0)), wr,
          ($urandom_range(7, 0) == 0), ($urandom_range(15, 0) == 0), ($urandom_range(49, 0) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && (comb_q.size() > 0 || wb_q.size() > 0); k++) @(negedge clk);
    #1;
    checks++;
    if (comb_q.size() != 0 || wb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending_comb=%0d pending_wb=%0d expected=0", comb_q.size(), wb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
